branch_condition_unit: RTL
==========================

BRANCH_CONDITION_UNIT -- requirements
Module: branch_condition_unit

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: negative_sr, zero_sr, carry_sr, overflow_sr  input  1 each  committed NZCV flags from the status register.
REQ-004 SHALL have ports: negative_in, zero_in, carry_in, overflow_in  input  1 each  NZCV flags being written this cycle.
REQ-005 SHALL have port: update_sreg  input  1  status register write strobe this cycle.
REQ-006 SHALL have port: flag_issue  input  1  a flag-setting instruction issued this cycle; its write is still outstanding.
REQ-007 SHALL have ports: req_valid  input  1; req_ready  output  1  request handshake.
REQ-008 SHALL have ports: req_kind  input  2  00 B.cond, 01 CBZ, 10 CBNZ, 11 unconditional B.
REQ-009 SHALL have ports: req_cond  input  4  LEGv8 condition code; req_opnd_zero  input  1  CBZ/CBNZ register equals zero; req_tag  input  5  opaque ID.
REQ-010 SHALL have ports: resp_valid  output  1; resp_ready  input  1; resp_taken  output  1; resp_tag  output  5.
REQ-011 SHALL have ports: pending_count  output  2  outstanding flag writes; err_sticky  output  1  counter over/underflow seen.

Function
REQ-012 pending_count: +1 on flag_issue & !update_sreg, saturating at 3; -1 on update_sreg & !flag_issue, holding at 0; unchanged when both or neither are asserted.
REQ-013 An increment at 3 or a decrement at 0 SHALL set err_sticky; only reset clears it.
REQ-014 FSM states SHALL be IDLE, WAIT, RESP; req_ready = (state==IDLE) & !reset.
REQ-015 Acceptance occurs on a cycle where req_valid & req_ready; kind, cond, opnd_zero and tag are captured.
REQ-016 On acceptance, wait_cnt SHALL load pending_count, excluding any flag_issue in the same cycle, because the request is older than that issue.
REQ-017 On acceptance, the unit SHALL evaluate immediately and enter RESP when any of these hold:
- kind != 00;
- wait_cnt == 0: use the _sr flags;
- wait_cnt == 1 & update_sreg: use the _in flags.
REQ-018 Otherwise the unit SHALL enter WAIT.
REQ-019 In WAIT, each update_sreg SHALL decrement wait_cnt. The update_sreg that takes wait_cnt from 1 to 0 SHALL evaluate using the _in flags of that cycle and enter RESP.
REQ-020 Latency SHALL be: resp_valid one cycle after the evaluating cycle.
REQ-021 In RESP, resp_valid=1 and resp_taken/resp_tag SHALL be held stable until resp_ready. On resp_valid & resp_ready the FSM SHALL enter IDLE; there is no same-cycle new acceptance.
REQ-022 Condition evaluation SHALL follow this table:
- EQ(0) Z; NE(1) !Z; HS(2) C; LO(3) !C;
- MI(4) N; PL(5) !N; VS(6) V; VC(7) !V;
- HI(8) C&!Z; LS(9) !C|Z;
- GE(A) N==V; LT(B) N!=V; GT(C) !Z&(N==V); LE(D) Z|(N!=V);
- AL(E) 1; NV(F) 1.
REQ-023 CBZ taken = req_opnd_zero; CBNZ taken = !req_opnd_zero; unconditional taken = 1. These kinds SHALL ignore flags and pending_count.
REQ-024 pending_count SHALL keep tracking flag_issue/update_sreg in every FSM state.

Reset
REQ-025 Reset asserted at any time SHALL force within the same cycle: state IDLE, pending_count 0, wait_cnt 0, err_sticky 0, resp_valid 0, resp_taken 0, resp_tag 0, req_ready 0.
REQ-026 Reset asserted mid-WAIT or mid-RESP SHALL drop the in-flight request with no response.
REQ-027 After reset deasserts, req_ready SHALL be 1 on the first clock edge.

Verification
REQ-028 Flags N=0 Z=1 C=0 V=0, pending 0; B.cond EQ tag 5 accepted at T -> resp_valid at T+1, taken 1, tag 5; NE -> taken 0.
REQ-029 pending 2; B.cond GE accepted; update_sreg at T+2 (in N=1 V=0), then at T+4 (in N=1 V=1) -> resp_valid at T+5, taken 1.
REQ-030 pending 1; B.cond LT accepted in the same cycle as update_sreg (in N=1 V=0) while the _sr flags say N=0 V=0 -> resp at T+1, taken 1 (forwarded).
REQ-031 flag_issue in the acceptance cycle with pending 0; B.cond MI with N_sr=1 -> no wait, taken 1, pending_count becomes 1.
REQ-032 CBNZ opnd_zero=0 while pending 3 -> resp at T+1, taken 1; resp_ready held low 4 cycles -> outputs stable; then IDLE.
REQ-033 Three flag_issue pulses then a fourth -> pending_count 3, err_sticky 1. Reset during WAIT -> resp_valid 0, pending_count 0, err_sticky 0.

Source files
------------

// File: rtl/branch_condition_unit_if.sv
// Request/response channel between the issue stage and the branch condition unit.
// A transfer happens on a rising clk edge where valid & ready are both high; the
// sender holds its payload stable while valid is high, and valid never waits on ready.
interface branch_condition_unit_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_kind;
  logic [3:0] req_cond;
  logic       req_opnd_zero;
  logic [4:0] req_tag;
  logic       resp_valid;
  logic       resp_ready;
  logic       resp_taken;
  logic [4:0] resp_tag;

  modport master (
    output req_valid, req_kind, req_cond, req_opnd_zero, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_taken, resp_tag
  );

  modport slave (
    input  req_valid, req_kind, req_cond, req_opnd_zero, req_tag, resp_ready,
    output req_ready, resp_valid, resp_taken, resp_tag
  );
endinterface

// File: rtl/branch_condition_unit.sv
// Resolves LEGv8 branch outcomes, waiting for outstanding flag writes older than
// the branch and forwarding the flags being written on the cycle they land.
module branch_condition_unit (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    negative_sr,
  input  logic                    zero_sr,
  input  logic                    carry_sr,
  input  logic                    overflow_sr,
  input  logic                    negative_in,
  input  logic                    zero_in,
  input  logic                    carry_in,
  input  logic                    overflow_in,
  input  logic                    update_sreg,
  input  logic                    flag_issue,
  branch_condition_unit_if.slave  bus,
  output logic [1:0]              pending_count,
  output logic                    err_sticky,
  output logic [1:0]              fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t     state, state_nxt;
  logic [1:0] wait_cnt, wait_cnt_nxt;
  logic [3:0] cond_q;
  logic [4:0] tag_q;
  logic       resp_taken_q;
  logic [4:0] resp_tag_q;
  logic       accept;
  logic       eval_en;
  logic       eval_taken;
  logic [4:0] eval_tag;

  function automatic logic cond_eval(input logic [3:0] c, input logic n, input logic z,
                                     input logic cf, input logic v);
    logic r;
    case (c)
      4'h0:    r = z;
      4'h1:    r = !z;
      4'h2:    r = cf;
      4'h3:    r = !cf;
      4'h4:    r = n;
      4'h5:    r = !n;
      4'h6:    r = v;
      4'h7:    r = !v;
      4'h8:    r = cf & !z;
      4'h9:    r = !cf | z;
      4'hA:    r = (n == v);
      4'hB:    r = (n != v);
      4'hC:    r = !z & (n == v);
      4'hD:    r = z | (n != v);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  assign bus.req_ready  = (state == IDLE) & !reset;
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_taken = resp_taken_q;
  assign bus.resp_tag   = resp_tag_q;
  assign fsm_state      = state;
  assign accept         = bus.req_valid & bus.req_ready;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    eval_en      = 1'b0;
    eval_taken   = 1'b0;
    eval_tag     = tag_q;
    case (state)
      IDLE: begin
        if (accept) begin
          eval_tag = bus.req_tag;
          if (bus.req_kind != 2'b00) begin
            eval_en = 1'b1;
            case (bus.req_kind)
              2'b01:   eval_taken = bus.req_opnd_zero;
              2'b10:   eval_taken = !bus.req_opnd_zero;
              default: eval_taken = 1'b1;
            endcase
          end else if (pending_count == 2'd0) begin
            eval_en    = 1'b1;
            eval_taken = cond_eval(bus.req_cond, negative_sr, zero_sr, carry_sr, overflow_sr);
          end else if (pending_count == 2'd1 && update_sreg) begin
            eval_en    = 1'b1;
            eval_taken = cond_eval(bus.req_cond, negative_in, zero_in, carry_in, overflow_in);
          end else begin
            // A write landing in the acceptance cycle already retires one older write.
            state_nxt    = WAIT;
            wait_cnt_nxt = pending_count - {1'b0, update_sreg};
          end
        end
      end
      WAIT: begin
        if (update_sreg) begin
          if (wait_cnt <= 2'd1) begin
            eval_en    = 1'b1;
            eval_taken = cond_eval(cond_q, negative_in, zero_in, carry_in, overflow_in);
          end else begin
            wait_cnt_nxt = wait_cnt - 2'd1;
          end
        end
      end
      RESP: begin
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (eval_en) begin
      state_nxt    = RESP;
      wait_cnt_nxt = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wait_cnt     <= 2'd0;
      cond_q       <= 4'd0;
      tag_q        <= 5'd0;
      resp_taken_q <= 1'b0;
      resp_tag_q   <= 5'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (accept) begin
        cond_q <= bus.req_cond;
        tag_q  <= bus.req_tag;
      end
      if (eval_en) begin
        resp_taken_q <= eval_taken;
        resp_tag_q   <= eval_tag;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_count <= 2'd0;
      err_sticky    <= 1'b0;
    end else if (flag_issue && !update_sreg) begin
      if (pending_count == 2'd3) err_sticky <= 1'b1;
      else                       pending_count <= pending_count + 2'd1;
    end else if (update_sreg && !flag_issue) begin
      if (pending_count == 2'd0) err_sticky <= 1'b1;
      else                       pending_count <= pending_count - 2'd1;
    end
  end

endmodule
